mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//   Request/response controller between the CPU datapath and the 16x16 memory bank.
//   Accepts one command at a time (READ, WRITE, SWAP, FILL) over a valid/ready handshake.
//   Sequences the memory's we/addr/data pins and handles its 1-cycle registered-address read latency.
//   Returns read data over a valid/ready response channel.
// PARAMETERS
//   DW     16  data width; must match the memory word width
//   AW     4   address width; memory depth = 2**AW
// PORTS
//   clk         in   1   system clock; all logic is on posedge
//   rst_n       in   1   synchronous reset, active low
//   req_valid   in   1   command present
//   req_ready   out  1   controller can accept a command
//   req_op      in   2   00=READ 01=WRITE 10=SWAP 11=FILL
//   req_addr    in   AW  target address (ignored for FILL)
//   req_wdata   in   DW  write/swap/fill data
//   resp_valid  out  1   response available
//   resp_ready  in   1   consumer takes the response
//   resp_rdata  out  DW  READ: word read; SWAP: old word; WRITE/FILL: 0
//   mem_data    out  DW  to memory data
//   mem_addr    out  AW  to memory addr
//   mem_we      out  1   to memory we
//   mem_q       in   DW  from memory q (valid one cycle after addr is sampled)
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=IDLE; resp_valid=0; resp_rdata=0; latched op/addr/wdata=0;
//     fill counter=0. Outputs: mem_we=0, mem_addr=0, mem_data=0, req_ready=1 in the cycle after.
//   - A reset mid-operation aborts the operation. No further mem_we pulses occur.
//     Words already written, including a partial FILL, are left in memory.
//   - States: IDLE, RD_ADDR, RD_DATA, WR, FILL, RESP. req_ready=1 only in IDLE.
//   - Accept: req_valid && req_ready at a posedge latches op, addr and wdata.
//     Next state: READ/SWAP->RD_ADDR, WRITE->WR, FILL->FILL (counter=0).
//   - mem_addr is the latched addr. In FILL it is the counter.
//     mem_data is the latched wdata. All memory pins are driven from registers/state only,
//     never combinationally from req_*.
//   - mem_we=1 only in WR and FILL; 0 in every other state.
//   - RD_ADDR: mem_addr held; the memory samples it at the end of this cycle. Next state: RD_DATA.
//   - RD_DATA: mem_addr still held. mem_q is captured into resp_rdata at the end of this cycle.
//     Next state: READ->RESP, SWAP->WR.
//   - WR: a single cycle with mem_we=1. Next state is RESP. WRITE also clears resp_rdata to 0.
//   - FILL: mem_we=1 for 16 consecutive cycles with addr 0..15. The counter wraps 15->0 on exit.
//     After the cycle with addr 15, the next state is RESP and resp_rdata=0.
//   - RESP: resp_valid=1, held with resp_rdata stable until resp_valid && resp_ready at a posedge.
//     Then the state returns to IDLE. resp_ready is ignored in all other states.
//   - Latency (accept edge = T0), resp_valid first high after:
//     READ at T2; WRITE at T1; SWAP at T3; FILL at T16.
//   - Minimum command spacing: back-to-back commands need one IDLE cycle after the response handshake.
//     No pipelining and no overlap.
//   - SWAP is atomic w.r.t. this port: the old value is read before the write, in the same command.
//   - req_* values changing while not in IDLE have no effect.
// TESTING
//   1. Reset, then WRITE addr=3 data=16'hBEEF -> one mem_we pulse at addr 3; resp_valid at T1 with rdata 0.
//   2. READ addr=3 after test 1 -> no mem_we; resp_valid at T2, resp_rdata=16'hBEEF.
//   3. SWAP addr=3 data=16'h1234 -> resp_rdata=16'hBEEF at T3; a following READ 3 returns 16'h1234.
//   4. FILL data=16'hA5A5 -> 16 mem_we cycles, addr 0..15 in order; all READs return 16'hA5A5;
//      resp_valid at T16.
//   5. Hold resp_ready=0 for 5 cycles after READ -> resp_valid and resp_rdata stable; req_ready=0 throughout;
//      a new req_valid is not accepted.
//   6. rst_n=0 during FILL at addr 7 -> mem_we=0 from the next cycle; addrs 0..7 hold 16'hA5A5;
//      addr 8..15 keep their old values; resp_valid=0.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - command sequencer between CPU datapath and a 16x16 registered-address memory bank
module mem_ctrl #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic [DW-1:0] mem_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  localparam logic [AW-1:0] FILL_LAST = '1;
  localparam logic [AW-1:0] FILL_STEP = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_FILL,
    S_RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] fill_cnt;
  logic [DW-1:0] rdata_q;
  logic          accept;
  logic          fill_last;

  assign accept    = (state == S_IDLE) && req_valid;
  assign fill_last = (fill_cnt == FILL_LAST);

  // State register; reset aborts any command in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: one command at a time, SWAP reads before it writes
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          unique case (req_op)
            OP_READ:  state_nxt = S_RD_ADDR;
            OP_SWAP:  state_nxt = S_RD_ADDR;
            OP_WRITE: state_nxt = S_WR;
            OP_FILL:  state_nxt = S_FILL;
            default:  state_nxt = S_IDLE;
          endcase
        end
      end
      S_RD_ADDR: state_nxt = S_RD_DATA;
      S_RD_DATA: state_nxt = (op_q == OP_SWAP) ? S_WR : S_RESP;
      S_WR:      state_nxt = S_RESP;
      S_FILL:    state_nxt = fill_last ? S_RESP : S_FILL;
      S_RESP:    state_nxt = resp_ready ? S_IDLE : S_RESP;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Command latch, fill counter and response data; req_* only matters at accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      fill_cnt <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (req_op == OP_FILL) begin
          fill_cnt <= '0;
        end
      end
      if (state == S_RD_DATA) begin
        rdata_q <= mem_q;
      end
      if ((state == S_WR) && (op_q == OP_WRITE)) begin
        rdata_q <= '0;
      end
      if (state == S_FILL) begin
        fill_cnt <= fill_cnt + FILL_STEP;
        if (fill_last) begin
          rdata_q <= '0;
        end
      end
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign mem_we     = (state == S_WR) || (state == S_FILL);
  assign mem_addr   = (state == S_FILL) ? fill_cnt : addr_q;
  assign mem_data   = wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed and randomized self-checking bench for mem_ctrl
module tb_mem_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_q;

  mem_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Memory bank: synchronous write, registered read address
  logic [DW-1:0] bank [DEPTH];
  logic [AW-1:0] bank_a;
  always @(posedge clk) begin
    if (mem_we) bank[mem_addr] <= mem_data;
    bank_a <= mem_addr;
  end
  assign mem_q = bank[bank_a];

  // Log of every write pulse seen on the memory pins
  int            log_addr [$];
  int            log_data [$];
  always @(posedge clk) begin
    if (mem_we) begin
      log_addr.push_back(int'(mem_addr));
      log_data.push_back(int'(mem_data));
    end
  end

  // Reference model of memory contents
  logic [DW-1:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_req();
    req_op    = 2'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic accept(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    log_addr.delete();
    log_data.delete();
    step();
    req_valid = 1'($urandom);
    scramble_req();
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    chk("resp_valid_t0", 32'(resp_valid), 32'd0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int hold);
    int            exp_lat;
    logic [DW-1:0] exp_rd;
    int            exp_wa [$];
    int            exp_wd [$];
    int            lat;
    case (op)
      2'b00: begin exp_lat = 2;  exp_rd = ref_mem[a]; end
      2'b01: begin exp_lat = 1;  exp_rd = '0; ref_mem[a] = d; exp_wa.push_back(int'(a)); exp_wd.push_back(int'(d)); end
      2'b10: begin exp_lat = 3;  exp_rd = ref_mem[a]; ref_mem[a] = d; exp_wa.push_back(int'(a)); exp_wd.push_back(int'(d)); end
      default: begin
        exp_lat = DEPTH; exp_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
          ref_mem[i] = d; exp_wa.push_back(i); exp_wd.push_back(int'(d));
        end
      end
    endcase
    accept(op, a, d);
    lat = 0;
    do begin
      step();
      lat++;
      req_valid = 1'($urandom);
      scramble_req();
    end while (!resp_valid && lat < 40);
    chk($sformatf("latency_op%0d", op), 32'(lat), 32'(exp_lat));
    chk($sformatf("rdata_op%0d_a%0d", op, a), 32'(resp_rdata), 32'(exp_rd));
    for (int i = 0; i < hold; i++) begin
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      scramble_req();
      step();
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", 32'(resp_rdata), 32'(exp_rd));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("post_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk($sformatf("nwrites_op%0d", op), 32'(log_addr.size()), 32'(exp_wa.size()));
    if (log_addr.size() == exp_wa.size()) begin
      for (int i = 0; i < exp_wa.size(); i++) begin
        chk("write_addr", 32'(log_addr[i]), 32'(exp_wa[i]));
        chk("write_data", 32'(log_data[i]), 32'(exp_wd[i]));
      end
    end
  endtask

  initial begin
    logic [DW-1:0] fd;
    for (int i = 0; i < DEPTH; i++) begin
      bank[i]    = DW'($urandom);
      ref_mem[i] = bank[i];
    end
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 2'b00; req_addr = '0; req_wdata = '0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    step();

    do_cmd(2'b01, 4'd3, 16'hBEEF, 0);
    do_cmd(2'b00, 4'd3, 16'h0000, 0);
    do_cmd(2'b10, 4'd3, 16'h1234, 0);
    do_cmd(2'b00, 4'd3, 16'h0000, 0);
    do_cmd(2'b11, 4'd0, 16'hA5A5, 0);
    for (int i = 0; i < DEPTH; i++) do_cmd(2'b00, AW'(i), 16'h0000, 0);
    do_cmd(2'b00, 4'd9, 16'h0000, 5);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_cmd(op, AW'($urandom), DW'($urandom), $urandom_range(0, 3));
    end
    for (int i = 8; i < DEPTH; i++) do_cmd(2'b01, AW'(i), DW'($urandom), 0);

    fd = 16'hA5A5;
    accept(2'b11, 4'd0, fd);
    repeat (7) step();
    chk("fill_addr7", 32'(mem_addr), 32'd7);
    chk("fill_we7", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    step();
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) ref_mem[i] = fd;
    step();
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_nwrites", 32'(log_addr.size()), 32'd8);
    for (int i = 0; i < DEPTH; i++) do_cmd(2'b00, AW'(i), 16'h0000, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
